// File: rtl/pll_bringup_seq.sv
// ---------------------------------------------------------------------------
// pll_bringup_seq
//   Sequences PLL bring-up and reconfiguration, and drives the system clock
//   mux select. While the PLL divider changes or the PLL settles, the PLL is
//   held in reset and the mux selects the external clock. The mux is handed
//   to the PLL only after the guard, reset and settle intervals have elapsed.
//   Runs on clk_ext, which is free-running and never the muxed system clock.
//
// Ports
//   clk          in   reference clock (clk_ext domain)
//   rst          in   asynchronous reset, active-high
//   cfg_valid    in   configuration request valid
//   cfg_ready    out  request accepted when cfg_valid & cfg_ready
//   cfg_en       in   1 = run PLL with cfg_div, 0 = shut PLL down
//   cfg_div      in   requested PLL divider select
//   pll_rst_n    out  PLL reset, active-low
//   pll_div_sel  out  PLL divider select
//   clk_sel      out  clock mux select: 0 = clk_ext, 1 = pll_clk
//   busy         out  sequence in progress
//   done         out  one-cycle pulse on entry to IDLE (from SW_OFF) or RUN
// ---------------------------------------------------------------------------
module pll_bringup_seq #(
    parameter int unsigned GUARD_CYCLES  = 8,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter int unsigned CNT_W         = 16,
    parameter logic [3:0]  DEFAULT_DIV   = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       cfg_en,
    input  logic [3:0] cfg_div,
    output logic       pll_rst_n,
    output logic [3:0] pll_div_sel,
    output logic       clk_sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SW_OFF,
        S_PRST,
        S_SETTLE,
        S_SW_ON,
        S_RUN
    } state_t;

    // Terminal count of each wait state: a state lasting N cycles ends at N-1.
    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_q, en_d;
    logic [3:0]       div_q, div_d;
    logic             pll_rst_n_q, pll_rst_n_d;
    logic [3:0]       div_sel_q, div_sel_d;
    logic             clk_sel_q, clk_sel_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        en_d        = en_q;
        div_d       = div_q;
        pll_rst_n_d = pll_rst_n_q;
        div_sel_d   = div_sel_q;
        clk_sel_d   = clk_sel_q;
        ready_d     = ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE, S_RUN: begin
                cnt_d = '0;
                // Every accepted request re-sequences, even an identical one.
                if (cfg_valid) begin
                    state_d   = S_SW_OFF;
                    en_d      = cfg_en;
                    div_d     = cfg_div;
                    clk_sel_d = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            S_SW_OFF: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d       = '0;
                    pll_rst_n_d = 1'b0;
                    if (en_q) begin
                        state_d   = S_PRST;
                        // Divider only changes while the PLL is held in reset.
                        div_sel_d = div_q;
                    end else begin
                        state_d = S_IDLE;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_PRST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d       = '0;
                    state_d     = S_SETTLE;
                    pll_rst_n_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SW_ON;
                end
            end
            S_SW_ON: begin
                if (cnt_q == GUARD_LAST) begin
                    cnt_d     = '0;
                    state_d   = S_RUN;
                    clk_sel_d = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b0;
            div_q       <= DEFAULT_DIV;
            pll_rst_n_q <= 1'b0;
            div_sel_q   <= DEFAULT_DIV;
            clk_sel_q   <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            div_q       <= div_d;
            pll_rst_n_q <= pll_rst_n_d;
            div_sel_q   <= div_sel_d;
            clk_sel_q   <= clk_sel_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cfg_ready   = ready_q;
    assign pll_rst_n   = pll_rst_n_q;
    assign pll_div_sel = div_sel_q;
    assign clk_sel     = clk_sel_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pll_bringup_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_bringup_seq
//   Self-checking bench for pll_bringup_seq with short intervals
//   (GUARD=2, RST=3, SETTLE=5). A reference model describes the expected
//   outputs as a function of the time elapsed since the accepted request.
// ---------------------------------------------------------------------------
module tb_pll_bringup_seq;

    localparam int G = 2;
    localparam int R = 3;
    localparam int S = 5;
    localparam int RUN_AT = 2 * G + R + S;   // edges after accept edge

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_en;
    logic [3:0] cfg_div;
    logic       pll_rst_n;
    logic [3:0] pll_div_sel;
    logic       clk_sel;
    logic       busy;
    logic       done;

    pll_bringup_seq #(
        .GUARD_CYCLES (G),
        .RST_CYCLES   (R),
        .SETTLE_CYCLES(S),
        .CNT_W        (16),
        .DEFAULT_DIV  (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_en     (cfg_en),
        .cfg_div    (cfg_div),
        .pll_rst_n  (pll_rst_n),
        .pll_div_sel(pll_div_sel),
        .clk_sel    (clk_sel),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Reference model: sequence-in-progress flag, edges elapsed since the
    // accept edge, the latched request and the expected outputs.
    bit         m_seq;
    int         m_e;
    bit         m_en;
    logic [3:0] m_div;
    logic       x_rstn;
    logic [3:0] x_div;
    logic       x_clk;
    logic       x_ready;
    logic       x_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_seq   = 1'b0;
        m_e     = 0;
        m_en    = 1'b0;
        m_div   = 4'd0;
        x_rstn  = 1'b0;
        x_div   = 4'd0;
        x_clk   = 1'b0;
        x_ready = 1'b1;
        x_done  = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic en, input logic [3:0] div);
        x_done = 1'b0;
        if (!m_seq) begin
            if (v) begin
                m_seq   = 1'b1;
                m_e     = 0;
                m_en    = en;
                m_div   = div;
                x_clk   = 1'b0;
                x_ready = 1'b0;
            end
        end else begin
            m_e++;
            if (m_en) begin
                if (m_e == G) begin
                    x_rstn = 1'b0;
                    x_div  = m_div;
                end
                if (m_e == G + R) x_rstn = 1'b1;
                if (m_e == RUN_AT) begin
                    x_clk   = 1'b1;
                    x_ready = 1'b1;
                    x_done  = 1'b1;
                    m_seq   = 1'b0;
                end
            end else if (m_e == G) begin
                x_rstn  = 1'b0;
                x_ready = 1'b1;
                x_done  = 1'b1;
                m_seq   = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("cfg_ready",   32'(cfg_ready),   32'(x_ready));
        chk("busy",        32'(busy),        32'(!x_ready));
        chk("pll_rst_n",   32'(pll_rst_n),   32'(x_rstn));
        chk("pll_div_sel", 32'(pll_div_sel), 32'(x_div));
        chk("clk_sel",     32'(clk_sel),     32'(x_clk));
        chk("done",        32'(done),        32'(x_done));
    endtask

    // One clock cycle: drive at negedge, model at posedge, check 1 time unit later.
    task automatic tick(input logic v, input logic en, input logic [3:0] div);
        @(negedge clk);
        cfg_valid = v;
        cfg_en    = en;
        cfg_div   = div;
        @(posedge clk);
        model_step(v, en, div);
        #1;
        compare_all();
    endtask

    // Asynchronous reset: outputs must take reset values before any clock edge.
    task automatic apply_reset();
        @(negedge clk);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        #1;
        chk("rst_pll_rst_n", 32'(pll_rst_n),   32'd0);
        chk("rst_clk_sel",   32'(clk_sel),     32'd0);
        chk("rst_ready",     32'(cfg_ready),   32'd1);
        chk("rst_div_sel",   32'(pll_div_sel), 32'd0);
        chk("rst_done",      32'(done),        32'd0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic       en;
        logic [3:0] div;
        int         lat;
        logic       clk_s;
        logic       rstn;
        logic [3:0] divsel;
    } vec_t;

    vec_t vecs[7];
    int   lat;
    int   hi_cnt;

    initial begin
        vecs[0] = '{en: 1'b1, div: 4'h5, lat: 13, clk_s: 1'b1, rstn: 1'b1, divsel: 4'h5};
        vecs[1] = '{en: 1'b1, div: 4'hA, lat: 13, clk_s: 1'b1, rstn: 1'b1, divsel: 4'hA};
        vecs[2] = '{en: 1'b0, div: 4'h7, lat: 3,  clk_s: 1'b0, rstn: 1'b0, divsel: 4'hA};
        vecs[3] = '{en: 1'b0, div: 4'h2, lat: 3,  clk_s: 1'b0, rstn: 1'b0, divsel: 4'hA};
        vecs[4] = '{en: 1'b1, div: 4'hC, lat: 13, clk_s: 1'b1, rstn: 1'b1, divsel: 4'hC};
        vecs[5] = '{en: 1'b1, div: 4'hC, lat: 13, clk_s: 1'b1, rstn: 1'b1, divsel: 4'hC};
        vecs[6] = '{en: 1'b1, div: 4'h3, lat: 13, clk_s: 1'b1, rstn: 1'b1, divsel: 4'h3};

        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_en    = 1'b0;
        cfg_div   = 4'd0;
        model_reset();
        #12;
        apply_reset();

        // Table-driven requests, each held valid for the accept cycle only.
        for (int i = 0; i < 7; i++) begin
            chk("ready_before_req", 32'(cfg_ready), 32'd1);
            tick(1'b1, vecs[i].en, vecs[i].div);
            lat = 1;
            while (done !== 1'b1 && lat < 100) begin
                tick(1'b0, 1'b0, 4'd0);
                lat++;
            end
            chk("latency",     32'(lat),         32'(vecs[i].lat));
            chk("end_clk_sel", 32'(clk_sel),     32'(vecs[i].clk_s));
            chk("end_rst_n",   32'(pll_rst_n),   32'(vecs[i].rstn));
            chk("end_div_sel", 32'(pll_div_sel), 32'(vecs[i].divsel));
        end

        // Request pulsed while busy (in SETTLE) is ignored.
        tick(1'b1, 1'b1, 4'h6);
        for (int k = 0; k < G + R + 1; k++) tick(1'b0, 1'b0, 4'd0);
        chk("settle_rst_n", 32'(pll_rst_n), 32'd1);
        tick(1'b1, 1'b0, 4'h9);
        lat = G + R + 3;
        while (done !== 1'b1 && lat < 100) begin
            tick(1'b0, 1'b0, 4'd0);
            lat++;
        end
        chk("busy_ignore_lat", 32'(lat),         32'd13);
        chk("busy_ignore_div", 32'(pll_div_sel), 32'h6);
        chk("busy_ignore_clk", 32'(clk_sel),     32'd1);

        // Reset pulsed during SETTLE: immediate return to reset values.
        tick(1'b1, 1'b1, 4'h8);
        for (int k = 0; k < G + R + 1; k++) tick(1'b0, 1'b0, 4'd0);
        chk("pre_rst_settle", 32'(pll_rst_n), 32'd1);
        apply_reset();
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b0, 4'd0);

        // Back-to-back: request held valid across the done cycle.
        lat = 0;
        tick(1'b1, 1'b1, 4'h4);
        while (done !== 1'b1 && lat < 100) begin
            tick(1'b1, 1'b1, 4'hB);
            lat++;
        end
        chk("b2b_done_clk", 32'(clk_sel), 32'd1);
        tick(1'b1, 1'b1, 4'hB);
        chk("b2b_reaccept_clk",  32'(clk_sel), 32'd0);
        chk("b2b_reaccept_busy", 32'(busy),    32'd1);
        hi_cnt = 0;
        lat    = 0;
        while (done !== 1'b1 && lat < 100) begin
            tick(1'b0, 1'b0, 4'd0);
            lat++;
        end
        chk("b2b_second_lat", 32'(lat + 1), 32'd13);
        chk("b2b_second_div", 32'(pll_div_sel), 32'hB);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                apply_reset();
            end else begin
                tick(($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
                     4'($urandom_range(0, 15)));
                if (clk_sel) hi_cnt++;
            end
        end
        chk("random_reached_run", 32'(hi_cnt > 0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

endmodule
